regfile_dump: RTL

Debug readout engine that walks every register of the 32×32 register file through one of its asynchronous read ports and streams the contents out as a valid/ready word stream. It sits beside the register file on the debug path and owns a read-address mux input while busy. It is the reader counterpart to the core's writeback port: it never writes the file.

---
 rtl/regfile_dump_pkg.sv | 7 +
 rtl/regfile_dump_if.sv | 24 ++
 rtl/regfile_dump.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_dump_pkg.sv
// regdump_pkg: shared register-file geometry and the dump engine state encoding
package regdump_pkg;
  localparam int REGDUMP_NUM_REGS = 32;
  localparam int REGDUMP_ADDR_W = 5;
  localparam int REGDUMP_DATA_W = 32;
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CKSUM, DONE} state_t;
endpackage

// File: rtl/regfile_dump_if.sv
// regfile_dump_if: dump control, register-file read port and output word stream
interface regfile_dump_if #(
  parameter int ADDR_W = regdump_pkg::REGDUMP_ADDR_W,
  parameter int DATA_W = regdump_pkg::REGDUMP_DATA_W
);
  logic start;
  logic busy;
  logic done;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic out_last;
  modport master (
    input start, rf_read_data, out_ready,
    output busy, done, rf_read_addr, out_valid, out_data, out_addr, out_last
  );
  modport slave (
    output start, rf_read_data, out_ready,
    input busy, done, rf_read_addr, out_valid, out_data, out_addr, out_last
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: streams every register of the file out as valid/ready beats.
// Define REGDUMP_CHECKSUM_EN to append an XOR-checksum beat after the last register.
module regfile_dump
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = REGDUMP_NUM_REGS,
  parameter int ADDR_W = REGDUMP_ADDR_W,
  parameter int DATA_W = REGDUMP_DATA_W
) (
  input logic clk,
  input logic rst_n,
  regfile_dump_if.master bus
);
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd;
  logic last;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] cksum;
`endif
  assign rd = bus.rf_read_data;
  assign last = addr == ADDR_W'(NUM_REGS - 1);
  assign bus.rf_read_addr = addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_addr <= '0;
      bus.out_last <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      cksum <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          addr <= '0;
          bus.busy <= 1'b1;
          state <= FETCH;
`ifdef REGDUMP_CHECKSUM_EN
          cksum <= '0;
`endif
        end
        FETCH: begin
          bus.out_data <= rd;
          bus.out_addr <= addr;
          bus.out_valid <= 1'b1;
          state <= SEND;
`ifdef REGDUMP_CHECKSUM_EN
          bus.out_last <= 1'b0;
          cksum <= cksum ^ rd;
`else
          bus.out_last <= last;
`endif
        end
        SEND: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          if (!last) begin
            addr <= addr + 1'b1;
            state <= FETCH;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            // checksum beat follows immediately; no fetch cycle needed
            bus.out_valid <= 1'b1;
            bus.out_data <= cksum;
            bus.out_addr <= '0;
            bus.out_last <= 1'b1;
            state <= CKSUM;
`else
            bus.done <= 1'b1;
            state <= DONE;
`endif
          end
        end
        CKSUM: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          addr <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
